// File: rtl/falafel_pkg.sv
// Shared falafel types and constants, including the client arbiter's state,
// request record and client limit.
package falafel_pkg;

  localparam int unsigned DATA_W          = 32;
  localparam int unsigned ARB_MAX_CLIENTS = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DELIVER
  } arb_state_e;

  typedef struct packed {
    logic              is_alloc;
    logic [DATA_W-1:0] data;
  } client_req_t;

endpackage

// File: rtl/falafel_rr_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr_i,
// wrapping around the client range.
module falafel_rr_picker #(
  parameter int unsigned NUM_CLIENTS = 4,
  parameter int unsigned IDX_W       = $clog2(NUM_CLIENTS)
) (
  input  logic [NUM_CLIENTS-1:0] req_i,
  input  logic [IDX_W-1:0]       ptr_i,
  output logic [IDX_W-1:0]       grant_idx_o,
  output logic                   any_o
);

  int unsigned cand;

  always_comb begin
    grant_idx_o = '0;
    any_o       = 1'b0;
    cand        = 0;
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      // ptr_i is always below NUM_CLIENTS, so one subtraction folds the wrap.
      cand = 32'(ptr_i) + i;
      if (cand >= NUM_CLIENTS) begin
        cand = cand - NUM_CLIENTS;
      end
      if (!any_o && req_i[IDX_W'(cand)]) begin
        any_o       = 1'b1;
        grant_idx_o = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/falafel_client_arbiter.sv
// Round-robin front end sharing the falafel allocator between NUM_CLIENTS
// requesters, one outstanding transaction at a time with a response watchdog.
module falafel_client_arbiter
  import falafel_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_CLIENTS-1:0]        cl_req_val_i,
  output logic [NUM_CLIENTS-1:0]        cl_req_rdy_o,
  input  logic [NUM_CLIENTS-1:0]        cl_req_is_alloc_i,
  input  logic [NUM_CLIENTS*DATA_W-1:0] cl_req_data_i,
  output logic [NUM_CLIENTS-1:0]        cl_rsp_val_o,
  input  logic [NUM_CLIENTS-1:0]        cl_rsp_rdy_i,
  output logic [DATA_W-1:0]             cl_rsp_data_o,
  output logic                          cl_rsp_err_o,
  output logic                          fa_req_val_o,
  input  logic                          fa_core_rdy_i,
  output logic                          fa_is_alloc_o,
  output logic [DATA_W-1:0]             fa_addr_to_free_o,
  output logic [DATA_W-1:0]             fa_size_o,
  input  logic                          fa_rsp_val_i,
  input  logic [DATA_W-1:0]             fa_rsp_data_i
);

  localparam int unsigned     IDX_W    = $clog2(NUM_CLIENTS);
  localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CLIENTS - 1);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  client_req_t       req_q, req_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  logic [IDX_W-1:0]  grant_idx;
  logic              any_req;
  logic [DATA_W-1:0] cl_data [NUM_CLIENTS];

  always_comb begin
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      cl_data[i] = cl_req_data_i[i*DATA_W +: DATA_W];
    end
  end

  falafel_rr_picker #(
    .NUM_CLIENTS (NUM_CLIENTS),
    .IDX_W       (IDX_W)
  ) u_picker (
    .req_i       (cl_req_val_i),
    .ptr_i       (rr_ptr_q),
    .grant_idx_o (grant_idx),
    .any_o       (any_req)
  );

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    req_d        = req_q;
    cnt_d        = cnt_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    cl_req_rdy_o = '0;
    cl_rsp_val_o = '0;
    fa_req_val_o = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Ready is combinational, so it must be masked while reset is held.
        if (any_req && !rst_i) begin
          cl_req_rdy_o[grant_idx] = 1'b1;
          owner_d                 = grant_idx;
          req_d.is_alloc          = cl_req_is_alloc_i[grant_idx];
          req_d.data              = cl_data[grant_idx];
          if (cl_req_is_alloc_i[grant_idx] && (cl_data[grant_idx] == '0)) begin
            rsp_data_d = '0;
            rsp_err_d  = 1'b0;
            state_d    = DELIVER;
          end else begin
            state_d = ISSUE;
          end
        end
      end

      ISSUE: begin
        fa_req_val_o = 1'b1;
        if (fa_core_rdy_i) begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end

      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (fa_rsp_val_i) begin
          rsp_data_d = fa_rsp_data_i;
          rsp_err_d  = 1'b0;
          state_d    = DELIVER;
        end else if (cnt_q == CNT_LAST) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = DELIVER;
        end
      end

      DELIVER: begin
        cl_rsp_val_o[owner_q] = 1'b1;
        if (cl_rsp_rdy_i[owner_q]) begin
          rr_ptr_d = (owner_q == IDX_LAST) ? '0 : owner_q + 1'b1;
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      req_q      <= '0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      req_q      <= req_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign fa_is_alloc_o     = req_q.is_alloc;
  assign fa_size_o         = req_q.is_alloc ? req_q.data : '0;
  assign fa_addr_to_free_o = req_q.is_alloc ? '0 : req_q.data;
  assign cl_rsp_data_o     = rsp_data_q;
  assign cl_rsp_err_o      = rsp_err_q;

endmodule

// File: tb/tb_falafel_client_arbiter.sv
// Randomized transaction-level bench for falafel_client_arbiter; the bench
// plays both the clients and the allocator.
module tb_falafel_client_arbiter;
  import falafel_pkg::*;

  localparam int unsigned NC = 4;
  localparam int          TO = 8;

  logic                 clk = 1'b0;
  logic                 rst_i;
  logic [NC-1:0]        cl_req_val_i;
  logic [NC-1:0]        cl_req_rdy_o;
  logic [NC-1:0]        cl_req_is_alloc_i;
  logic [NC*DATA_W-1:0] cl_req_data_i;
  logic [NC-1:0]        cl_rsp_val_o;
  logic [NC-1:0]        cl_rsp_rdy_i;
  logic [DATA_W-1:0]    cl_rsp_data_o;
  logic                 cl_rsp_err_o;
  logic                 fa_req_val_o;
  logic                 fa_core_rdy_i;
  logic                 fa_is_alloc_o;
  logic [DATA_W-1:0]    fa_addr_to_free_o;
  logic [DATA_W-1:0]    fa_size_o;
  logic                 fa_rsp_val_i;
  logic [DATA_W-1:0]    fa_rsp_data_i;

  always #5 clk = ~clk;

  falafel_client_arbiter #(
    .NUM_CLIENTS    (NC),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .cl_req_val_i      (cl_req_val_i),
    .cl_req_rdy_o      (cl_req_rdy_o),
    .cl_req_is_alloc_i (cl_req_is_alloc_i),
    .cl_req_data_i     (cl_req_data_i),
    .cl_rsp_val_o      (cl_rsp_val_o),
    .cl_rsp_rdy_i      (cl_rsp_rdy_i),
    .cl_rsp_data_o     (cl_rsp_data_o),
    .cl_rsp_err_o      (cl_rsp_err_o),
    .fa_req_val_o      (fa_req_val_o),
    .fa_core_rdy_i     (fa_core_rdy_i),
    .fa_is_alloc_o     (fa_is_alloc_o),
    .fa_addr_to_free_o (fa_addr_to_free_o),
    .fa_size_o         (fa_size_o),
    .fa_rsp_val_i      (fa_rsp_val_i),
    .fa_rsp_data_i     (fa_rsp_data_i)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int rr_m    = 0;   // client the next round-robin search starts from

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [NC-1:0] mask);
    for (int i = 0; i < int'(NC); i++) begin
      int c;
      c = (rr_m + i) % int'(NC);
      if (((mask >> c) & 4'd1) != 4'd0) return c;
    end
    return 0;
  endfunction

  function automatic logic [NC*DATA_W-1:0] pack(input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                                                input logic [DATA_W-1:0] d2, input logic [DATA_W-1:0] d3);
    return {d3, d2, d1, d0};
  endfunction

  // One full transaction: grant, optional issue/wait, delivery, handshake.
  // rsp_lat >= TO means the allocator never answers.
  task automatic do_txn(input logic [NC-1:0] mask, input logic [NC-1:0] alloc_v,
                        input logic [NC*DATA_W-1:0] data, input int core_wait,
                        input int rsp_lat, input logic [DATA_W-1:0] rsp_word, input int hold);
    int                w;
    logic [NC-1:0]     oh;
    logic              exp_alloc;
    logic [DATA_W-1:0] exp_d;
    logic [DATA_W-1:0] exp_rd;
    logic              exp_err;
    bit                timeout;

    cl_req_val_i      = mask;
    cl_req_is_alloc_i = alloc_v;
    cl_req_data_i     = data;
    w      = pick(mask);
    oh     = '0;
    oh[w]  = 1'b1;
    @(negedge clk);
    check("grant", cl_req_rdy_o, oh);
    check("idle_fa_val", fa_req_val_o, 0);
    step();

    exp_alloc    = alloc_v[w];
    exp_d        = data[w*DATA_W +: DATA_W];
    cl_req_val_i = NC'($urandom);
    timeout      = 1'b0;

    if (exp_alloc && exp_d == '0) begin
      exp_rd  = '0;
      exp_err = 1'b0;
    end else begin
      for (int c = 0; c <= core_wait; c++) begin
        fa_core_rdy_i = (c == core_wait);
        @(negedge clk);
        check("issue_val", fa_req_val_o, 1);
        check("issue_alloc", fa_is_alloc_o, exp_alloc);
        check("issue_size", fa_size_o, exp_alloc ? exp_d : 0);
        check("issue_free", fa_addr_to_free_o, exp_alloc ? 0 : exp_d);
        check("busy_rdy", cl_req_rdy_o, 0);
        step();
      end
      fa_core_rdy_i = 1'b0;
      timeout = (rsp_lat >= TO);
      for (int c = 0; c < (timeout ? TO : rsp_lat + 1); c++) begin
        fa_rsp_val_i  = !timeout && (c == rsp_lat);
        fa_rsp_data_i = fa_rsp_val_i ? rsp_word : $urandom;
        @(negedge clk);
        check("wait_rsp_val", cl_rsp_val_o, 0);
        check("wait_fa_val", fa_req_val_o, 0);
        check("busy_rdy", cl_req_rdy_o, 0);
        step();
      end
      fa_rsp_val_i = 1'b0;
      exp_rd  = timeout ? '0 : rsp_word;
      exp_err = timeout;
    end

    for (int c = 0; c <= hold; c++) begin
      cl_rsp_rdy_i  = (c == hold) ? oh : (NC'($urandom) & ~oh);
      fa_rsp_val_i  = (c == 0);   // stray allocator pulse outside WAIT
      fa_rsp_data_i = $urandom;
      @(negedge clk);
      check("rsp_val", cl_rsp_val_o, oh);
      check("rsp_data", cl_rsp_data_o, exp_rd);
      check("rsp_err", cl_rsp_err_o, exp_err);
      check("deliver_fa_val", fa_req_val_o, 0);
      check("busy_rdy", cl_req_rdy_o, 0);
      step();
    end
    cl_rsp_rdy_i = '0;
    fa_rsp_val_i = 1'b0;
    cl_req_val_i = '0;
    rr_m = (w + 1) % int'(NC);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_i             = 1'b1;
    cl_req_val_i      = '1;
    cl_req_is_alloc_i = '1;
    cl_req_data_i     = pack(32'd1, 32'd2, 32'd3, 32'd4);
    cl_rsp_rdy_i      = '1;
    fa_core_rdy_i     = 1'b0;
    fa_rsp_val_i      = 1'b0;
    fa_rsp_data_i     = '0;
    step();
    step();
    @(negedge clk);
    check("rst_req_rdy", cl_req_rdy_o, 0);
    check("rst_rsp_val", cl_rsp_val_o, 0);
    check("rst_rsp_data", cl_rsp_data_o, 0);
    check("rst_rsp_err", cl_rsp_err_o, 0);
    check("rst_fa_val", fa_req_val_o, 0);
    check("rst_fa_alloc", fa_is_alloc_o, 0);
    check("rst_fa_free", fa_addr_to_free_o, 0);
    check("rst_fa_size", fa_size_o, 0);
    step();
    rst_i        = 1'b0;
    cl_req_val_i = '0;
    cl_rsp_rdy_i = '0;
    rr_m         = 0;

    // All four clients valid: grants 0,1,2,3,0.
    for (int i = 0; i < 5; i++) begin
      do_txn(4'hF, 4'hF, pack(32'd16, 32'd32, 32'd48, 32'd80), 0, 1, 32'h100 + 32'(i), 0);
    end

    // Client 2 alloc of 64, allocator answers 0x1000 two cycles after accept.
    do_txn(4'b0100, 4'b0100, pack(32'd0, 32'd0, 32'd64, 32'd0), 0, 0, 32'h1000, 0);

    // Client 1 free of 0x2000.
    do_txn(4'b0010, 4'b0000, pack(32'd0, 32'h2000, 32'd0, 32'd0), 1, 2, 32'h0, 1);

    // Allocator never answers.
    do_txn(4'b0001, 4'b0001, pack(32'd24, 32'd0, 32'd0, 32'd0), 0, TO + 3, 32'hDEAD, 2);

    // Response on the final watchdog cycle wins over the timeout.
    do_txn(4'b1000, 4'b1000, pack(32'd0, 32'd0, 32'd0, 32'd12), 0, TO - 1, 32'h3300, 0);

    // Client 3 zero-size alloc never reaches the allocator.
    do_txn(4'b1000, 4'b1000, pack(32'd0, 32'd0, 32'd0, 32'd0), 0, 0, 32'h0, 1);

    // Reset in WAIT, then a response pulse: no delivery, grant restarts at client 0.
    cl_req_val_i      = 4'b0010;
    cl_req_is_alloc_i = 4'b0010;
    cl_req_data_i     = pack(32'd0, 32'd5, 32'd0, 32'd0);
    @(negedge clk);
    check("rstw_grant", cl_req_rdy_o, 4'b0010);
    step();
    cl_req_val_i  = '0;
    fa_core_rdy_i = 1'b1;
    step();
    fa_core_rdy_i = 1'b0;
    step();
    rst_i        = 1'b1;
    cl_req_val_i = '1;
    @(negedge clk);
    check("rstw_req_rdy", cl_req_rdy_o, 0);
    step();
    rst_i         = 1'b0;
    cl_req_val_i  = '0;
    fa_rsp_val_i  = 1'b1;
    fa_rsp_data_i = 32'h77;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("rstw_rsp_val", cl_rsp_val_o, 0);
      check("rstw_fa_val", fa_req_val_o, 0);
      step();
      fa_rsp_val_i = 1'b0;
    end
    rr_m = 0;
    do_txn(4'hF, 4'hF, pack(32'd9, 32'd9, 32'd9, 32'd9), 0, 0, 32'h4444, 0);

    // Randomized traffic.
    for (int t = 0; t < 80; t++) begin
      logic [DATA_W-1:0] d [NC];
      for (int i = 0; i < int'(NC); i++) begin
        d[i] = ($urandom_range(0, 3) == 0) ? '0 : DATA_W'($urandom);
      end
      do_txn(NC'($urandom_range(1, 15)), NC'($urandom), pack(d[0], d[1], d[2], d[3]),
             int'($urandom_range(0, 2)), int'($urandom_range(0, 10)), DATA_W'($urandom),
             int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/falafel_client_arbiter.md
# falafel_client_arbiter

Front-end scheduler that shares the single falafel allocator between `NUM_CLIENTS` requesters. It accepts alloc/free requests over per-client valid/ready handshakes and picks one client at a time by round-robin. It issues the winning request to the allocator, waits for the result under a watchdog, and routes the response back to the owning client. Only one transaction is outstanding at a time; it sits directly in front of the `falafel` top's request inputs.

## Interface
- `NUM_CLIENTS`, default 4: number of requesters, 2..16.
- `TIMEOUT_CYCLES`, default 1024: maximum wait for an allocator response before error completion; at least 2.
- `DATA_W`: taken from `falafel_pkg`; not overridable.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; synchronous, active-high; sampled on `clk_i` rising edge.
- `cl_req_val_i`  in  NUM_CLIENTS  per-client request valid.
- `cl_req_rdy_o`  out  NUM_CLIENTS  per-client request ready; at most one bit set.
- `cl_req_is_alloc_i`  in  NUM_CLIENTS  1 = allocate, 0 = free.
- `cl_req_data_i`  in  NUM_CLIENTS*DATA_W  size to allocate or address to free; client i occupies slice [i*DATA_W +: DATA_W].
- `cl_rsp_val_o`  out  NUM_CLIENTS  per-client response valid; at most one bit set.
- `cl_rsp_rdy_i`  in  NUM_CLIENTS  per-client response ready.
- `cl_rsp_data_o`  out  DATA_W  shared response data: allocated address, or 0.
- `cl_rsp_err_o`  out  1  response is a timeout error; valid with any `cl_rsp_val_o` bit.
- `fa_req_val_o`  out  1  drives allocator `req_alloc_valid_i`.
- `fa_core_rdy_i`  in  1  allocator ready to accept a request.
- `fa_is_alloc_o`  out  1  drives `is_alloc_i`.
- `fa_addr_to_free_o`  out  DATA_W  drives `addr_to_free_i`.
- `fa_size_o`  out  DATA_W  drives `size_to_allocate_i`.
- `fa_rsp_val_i`  in  1  allocator result valid; single-cycle pulse.
- `fa_rsp_data_i`  in  DATA_W  allocator result.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DELIVER.
- IDLE:
  - Round-robin grant among asserted `cl_req_val_i`, searching from `rr_ptr` upward with wrap.
  - `cl_req_rdy_o[grant]` is asserted combinationally in the same cycle; the handshake completes there.
  - Latch owner, is_alloc and data.
  - Alloc with size 0: go to DELIVER with data 0 and err 0; the allocator is not touched.
  - All other requests go to ISSUE.
- ISSUE:
  - `fa_req_val_o`=1 with the latched fields; the fields are held stable.
  - When `fa_core_rdy_i`=1, go to WAIT and clear the watchdog counter.
- WAIT:
  - The counter increments each cycle.
  - On `fa_rsp_val_i`, capture `fa_rsp_data_i`, set err=0, go to DELIVER.
  - If the counter reaches TIMEOUT_CYCLES-1 with no response, set data=0 and err=1, go to DELIVER.
  - A response arriving in the same cycle as the timeout wins: err=0.
- DELIVER:
  - `cl_rsp_val_o[owner]`=1; data and err are held.
  - On `cl_rsp_rdy_i[owner]`: `rr_ptr` ← (owner+1) mod NUM_CLIENTS, go to IDLE.
- `fa_rsp_val_i` outside WAIT is ignored; late responses after a timeout are dropped.
- `fa_addr_to_free_o` carries the latched data only for frees; otherwise it is 0. `fa_size_o` is the mirror case: latched data for allocs, 0 for frees.
- A client deasserting valid before its grant is legal. A client holding valid is served within NUM_CLIENTS transactions.

## Timing
- Reset: state IDLE, `rr_ptr`=0, counter 0.
  - Outputs are 0 at reset: `cl_rsp_val_o`, `cl_rsp_data_o`, `cl_rsp_err_o`, `fa_req_val_o`, `fa_is_alloc_o`, `fa_addr_to_free_o`, `fa_size_o`.
  - `cl_req_rdy_o` is 0 while `rst_i`=1.
- Reset mid-transaction aborts it with no response and returns to IDLE the next cycle.
- Acceptance cycle T: `fa_req_val_o` is high from T+1.
- Allocator response at cycle R: `cl_rsp_val_o` is high from R+1.
- Zero-size alloc: response valid at T+1.
- Minimum back-to-back period per transaction: accept, issue, response, deliver = 4 cycles when the allocator responds on the cycle after acceptance.
- No request is accepted while the FSM is outside IDLE.

## Structure
- Add to `falafel_pkg`:
  - `arb_state_e` enum.
  - `client_req_t` struct {is_alloc, data}.
  - `ARB_MAX_CLIENTS`=16.
- One sub-module `falafel_rr_picker`: combinational round-robin one-hot picker with inputs req vector and ptr, outputs grant index and any-valid.
- Counter width is $clog2(TIMEOUT_CYCLES).

## Test plan
- Single client 2 alloc size 64, allocator returns 0x1000 two cycles after accept:
  - `fa_size_o`=64 and `fa_is_alloc_o`=1 during ISSUE.
  - `cl_rsp_val_o`=4'b0100 with data 0x1000, err 0.
- All four clients valid continuously from reset: grants in order 0,1,2,3,0. No client is granted twice before all others are served.
- Client 1 free of 0x2000:
  - `fa_addr_to_free_o`=0x2000, `fa_size_o`=0, `fa_is_alloc_o`=0.
  - Response routed only to client 1.
- Allocator never responds, TIMEOUT_CYCLES=8:
  - Response valid exactly 8 cycles after WAIT entry, data 0, err 1.
  - A later `fa_rsp_val_i` is ignored.
- Client 3 alloc size 0: response data 0 at T+1; `fa_req_val_o` never asserts.
- `rst_i` pulsed during WAIT, then a response pulse arrives: no `cl_rsp_val_o`; next grant starts from client 0.
